// File: rtl/fractal_sync_pkg.sv
// Shared types and constants for the fractal-sync local controller.
package fractal_sync_pkg;

    // Widest barrier id a response record can carry; controllers use the low bits.
    localparam int unsigned RspIdMaxWidth = 16;

    // Idle RF id pair: distinct ids with check low, so the RF never reports bypass.
    localparam int unsigned IdleRfId0 = 0;
    localparam int unsigned IdleRfId1 = 1;

    typedef struct packed {
        logic [RspIdMaxWidth-1:0] id;
        logic                     err;
    } fractal_sync_rsp_t;

    // How a popped request head is handled in its issue cycle.
    typedef enum logic [1:0] {
        ClsIdle,
        ClsErr,
        ClsCheck
    } fractal_sync_cls_e;

    function automatic fractal_sync_rsp_t mk_rsp(input logic [RspIdMaxWidth-1:0] id,
                                                 input logic                     err);
        fractal_sync_rsp_t r;
        r.id  = id;
        r.err = err;
        return r;
    endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// Synchronous-reset FIFO accepting up to two ordered pushes per cycle.
// Slot 0 is written ahead of slot 1; slot 1 may be pushed alone.
// Pushing more than the free space (after this cycle's pop) is the caller's problem.
module fractal_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            push_i,
    input  logic [1:0][WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntW-1:0]       free_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, wr_ptr0, wr_ptr1;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    // Status flags and head data; head reads as zero when empty.
    always_comb begin
        full_o  = (cnt_q == CntW'(DEPTH));
        empty_o = (cnt_q == '0);
        free_o  = CntW'(DEPTH) - cnt_q;
        data_o  = empty_o ? '0 : mem_q[rptr_q];
    end

    // Pointer and occupancy next-state.
    always_comb begin
        pop_en  = pop_i & ~empty_o;
        wr_ptr0 = wptr_q;
        wr_ptr1 = push_i[0] ? ptr_inc(wptr_q) : wptr_q;
        wptr_d  = push_i[1] ? ptr_inc(wr_ptr1) : wr_ptr1;
        rptr_d  = pop_en ? ptr_inc(rptr_q) : rptr_q;
        cnt_d   = cnt_q + CntW'(push_i[0]) + CntW'(push_i[1]) - CntW'(pop_en);
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i[0]) mem_q[wr_ptr0] <= data_i[0];
        if (push_i[1]) mem_q[wr_ptr1] <= data_i[1];
    end

endmodule

// File: rtl/fractal_sync_1d_local_ctrl.sv
// Request front-end / response back-end for one 1D fractal-sync node.
// Buffers child requests, drives the local RF id/check pair, and turns the RF
// present/bypass/id_err replies into per-child completion or error responses.
module fractal_sync_1d_local_ctrl
    import fractal_sync_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned N_REGS    = 16,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][ID_WIDTH-1:0] req_id_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic [1:0][ID_WIDTH-1:0] rsp_id_o,
    output logic [1:0]               rsp_err_o,
    output logic [1:0][ID_WIDTH-1:0] rf_id_o,
    output logic [1:0]               rf_check_o,
    input  logic [1:0]               rf_present_i,
    input  logic [1:0]               rf_id_err_i,
    input  logic                     rf_bypass_i
);

    localparam int unsigned RspW    = ID_WIDTH + 1;
    localparam int unsigned ReqCntW = $clog2(REQ_DEPTH + 1);
    localparam int unsigned RspCntW = $clog2(RSP_DEPTH + 1);

    logic [1:0]                   req_push, req_full, req_empty;
    logic [1:0][ID_WIDTH-1:0]     head;
    logic [1:0][ReqCntW-1:0]      req_free;
    logic [1:0][1:0]              rsp_push;
    logic [1:0][1:0][RspW-1:0]    rsp_data;
    logic [1:0][RspW-1:0]         rsp_head;
    logic [1:0]                   rsp_full, rsp_empty;
    logic [1:0][RspCntW-1:0]      rsp_free;
    logic [1:0][N_REGS-1:0]       wait_q, wait_d;
    logic                         gate;
    logic [1:0]                   elig, cand;
    fractal_sync_cls_e            cls [2];
    logic                         bypass;
    logic                         unused_fifo;

    assign unused_fifo = ^{rsp_full, req_free};

    function automatic logic [RspW-1:0] pack_rsp(input fractal_sync_rsp_t r);
        return {r.id[ID_WIDTH-1:0], r.err};
    endfunction

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign req_push[p]    = req_valid_i[p] & ~req_full[p];
        assign req_ready_o[p] = ~req_full[p];
        assign rsp_valid_o[p] = ~rsp_empty[p];
        assign rsp_id_o[p]    = rsp_head[p][RspW-1:1];
        assign rsp_err_o[p]   = rsp_head[p][0];

        fractal_sync_fifo #(
            .WIDTH (ID_WIDTH),
            .DEPTH (REQ_DEPTH)
        ) u_req_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  ({1'b0, req_push[p]}),
            .data_i  ({{ID_WIDTH{1'b0}}, req_id_i[p]}),
            .pop_i   (elig[p]),
            .data_o  (head[p]),
            .full_o  (req_full[p]),
            .empty_o (req_empty[p]),
            .free_o  (req_free[p])
        );

        fractal_sync_fifo #(
            .WIDTH (RspW),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (rsp_push[p]),
            .data_i  (rsp_data[p]),
            .pop_i   (rsp_ready_i[p]),
            .data_o  (rsp_head[p]),
            .full_o  (rsp_full[p]),
            .empty_o (rsp_empty[p]),
            .free_o  (rsp_free[p])
        );
    end

    // Issue gate: a cycle can add two responses to either port, so both need room for two.
    // cand excludes re-requests of armed ids; it does not depend on RF replies, which keeps
    // the rf_id_o -> rf_id_err_i path loop-free.
    always_comb begin
        gate = (rsp_free[0] >= RspCntW'(2)) && (rsp_free[1] >= RspCntW'(2));
        for (int p = 0; p < 2; p++) begin
            elig[p] = ~req_empty[p] & gate;
            cand[p] = elig[p] & ~wait_q[p][head[p]];
        end
    end

    // RF id drive: an unused port takes the inverse of the active id so ids never collide.
    always_comb begin
        rf_id_o[0] = ID_WIDTH'(IdleRfId0);
        rf_id_o[1] = ID_WIDTH'(IdleRfId1);
        case (cand)
            2'b11: rf_id_o = head;
            2'b01: begin
                rf_id_o[0] = head[0];
                rf_id_o[1] = ~head[0];
            end
            2'b10: begin
                rf_id_o[0] = ~head[1];
                rf_id_o[1] = head[1];
            end
            default: ;
        endcase
    end

    // Classify each head; only an actual RF candidate consults its id_err reply.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (!elig[p])              cls[p] = ClsIdle;
            else if (!cand[p])         cls[p] = ClsErr;
            else if (rf_id_err_i[p])   cls[p] = ClsErr;
            else                       cls[p] = ClsCheck;
            rf_check_o[p] = (cls[p] == ClsCheck);
        end
        bypass = rf_check_o[0] & rf_check_o[1] & rf_bypass_i;
    end

    // Response generation and wait-vector update. Slot 0 carries the port's own
    // response, slot 1 a completion released on behalf of the partner.
    always_comb begin
        int o;
        wait_d   = wait_q;
        rsp_push = '0;
        rsp_data = '0;
        for (int p = 0; p < 2; p++) begin
            o = 1 - p;
            unique case (cls[p])
                ClsErr: begin
                    rsp_push[p][0] = 1'b1;
                    rsp_data[p][0] = pack_rsp(mk_rsp(RspIdMaxWidth'(head[p]), 1'b1));
                end
                ClsCheck: begin
                    if (bypass) begin
                        rsp_push[p][0] = 1'b1;
                        rsp_data[p][0] = pack_rsp(mk_rsp(RspIdMaxWidth'(head[p]), 1'b0));
                    end else if (!rf_present_i[p]) begin
                        wait_d[p][head[p]] = 1'b1;
                    end else begin
                        rsp_push[p][0] = 1'b1;
                        rsp_data[p][0] = pack_rsp(mk_rsp(RspIdMaxWidth'(head[p]), 1'b0));
                        if (wait_q[o][head[p]]) begin
                            wait_d[o][head[p]] = 1'b0;
                            rsp_push[o][1]     = 1'b1;
                            rsp_data[o][1]     = pack_rsp(mk_rsp(RspIdMaxWidth'(head[p]), 1'b0));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait-vector register.
    always_ff @(posedge clk_i) begin
        if (rst_i) wait_q <= '0;
        else       wait_q <= wait_d;
    end

endmodule

// File: tb/tb_fractal_sync_1d_local_ctrl.sv
// Directed bench with a behavioural 1D local RF and per-port response scoreboards.
module tb_fractal_sync_1d_local_ctrl;

    localparam int unsigned IdW = 4;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [1:0]          req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [1:0][IdW-1:0] req_id_i, rsp_id_o, rf_id_o;
    logic [1:0]          rf_check_o, rf_present_i, rf_id_err_i;
    logic                rf_bypass_i;
    logic [1:0]          inject_err;
    logic [15:0]         rf_bits;

    int n_assert = 0;
    int n_fail   = 0;

    logic [IdW:0] exp_q0 [$];
    logic [IdW:0] exp_q1 [$];
    logic [IdW:0] mon_e0, mon_e1;

    always #5 clk = ~clk;

    fractal_sync_1d_local_ctrl #(
        .ID_WIDTH  (IdW),
        .N_REGS    (16),
        .REQ_DEPTH (2),
        .RSP_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_err_o    (rsp_err_o),
        .rf_id_o      (rf_id_o),
        .rf_check_o   (rf_check_o),
        .rf_present_i (rf_present_i),
        .rf_id_err_i  (rf_id_err_i),
        .rf_bypass_i  (rf_bypass_i)
    );

    // Behavioural RF: equal checked ids bypass (write 0); otherwise each check toggles its bit.
    always_comb begin
        rf_present_i[0] = rf_bits[rf_id_o[0]];
        rf_present_i[1] = rf_bits[rf_id_o[1]];
        rf_bypass_i     = rf_check_o[0] & rf_check_o[1] & (rf_id_o[0] == rf_id_o[1]);
        rf_id_err_i     = inject_err;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rf_bits <= '0;
        end else if (rf_bypass_i) begin
            rf_bits[rf_id_o[0]] <= 1'b0;
        end else begin
            if (rf_check_o[0]) rf_bits[rf_id_o[0]] <= ~rf_bits[rf_id_o[0]];
            if (rf_check_o[1]) rf_bits[rf_id_o[1]] <= ~rf_bits[rf_id_o[1]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] v, input logic [IdW-1:0] id0,
                        input logic [IdW-1:0] id1);
        req_valid_i = v;
        req_id_i[0] = id0;
        req_id_i[1] = id1;
        tick();
        req_valid_i = 2'b00;
    endtask

    // Scoreboard: compare every response handshake against the queued expectation.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rsp_valid_o[0] && rsp_ready_i[0]) begin
                if (exp_q0.size() == 0) begin
                    chk("rsp0_unexpected", {rsp_id_o[0], rsp_err_o[0]}, 32'hFFFF_FFFF);
                end else begin
                    mon_e0 = exp_q0.pop_front();
                    chk("rsp0", {rsp_id_o[0], rsp_err_o[0]}, mon_e0);
                end
            end
            if (rsp_valid_o[1] && rsp_ready_i[1]) begin
                if (exp_q1.size() == 0) begin
                    chk("rsp1_unexpected", {rsp_id_o[1], rsp_err_o[1]}, 32'hFFFF_FFFF);
                end else begin
                    mon_e1 = exp_q1.pop_front();
                    chk("rsp1", {rsp_id_o[1], rsp_err_o[1]}, mon_e1);
                end
            end
        end
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 2'b00;
        req_id_i    = '0;
        rsp_ready_i = 2'b11;
        inject_err  = 2'b00;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset values
        chk("rst_req_ready", req_ready_o, 2'b11);
        chk("rst_rsp_valid", rsp_valid_o, 2'b00);
        chk("rst_rsp_id", rsp_id_o, 8'h00);
        chk("rst_rsp_err", rsp_err_o, 2'b00);
        chk("rst_rf_check", rf_check_o, 2'b00);
        chk("rst_rf_id", rf_id_o, 8'h10);

        // Bypass: both ports id 5 in one cycle
        send(2'b11, 4'd5, 4'd5);
        chk("byp_check", rf_check_o, 2'b11);
        chk("byp_bypass", rf_bypass_i, 1'b1);
        chk("byp_no_rsp_yet", rsp_valid_o, 2'b00);
        exp_q0.push_back({4'd5, 1'b0});
        exp_q1.push_back({4'd5, 1'b0});
        tick();
        chk("byp_latency2", rsp_valid_o, 2'b11);
        chk("byp_wait_zero", dut.wait_q, 32'h0);
        tick();

        // Arm on port 0, release from port 1 two cycles later
        send(2'b01, 4'd3, 4'd0);
        chk("arm_check", rf_check_o, 2'b01);
        chk("arm_idle_id", rf_id_o[1], 4'hC);
        chk("arm_present", rf_present_i[0], 1'b0);
        tick();
        chk("arm_no_rsp", rsp_valid_o, 2'b00);
        send(2'b10, 4'd0, 4'd3);
        chk("rel_check", rf_check_o, 2'b10);
        chk("rel_idle_id", rf_id_o[0], 4'hC);
        exp_q0.push_back({4'd3, 1'b0});
        exp_q1.push_back({4'd3, 1'b0});
        tick();
        chk("rel_both_valid", rsp_valid_o, 2'b11);
        tick();

        // Re-request of an armed id
        send(2'b01, 4'd7, 4'd0);
        tick();
        send(2'b01, 4'd7, 4'd0);
        chk("rereq_check", rf_check_o, 2'b00);
        exp_q0.push_back({4'd7, 1'b1});
        tick();
        chk("rereq_rf_bit", rf_bits[7], 1'b1);
        send(2'b10, 4'd0, 4'd7);
        exp_q1.push_back({4'd7, 1'b0});
        exp_q0.push_back({4'd7, 1'b0});
        tick();
        tick();
        chk("rereq_wait_clr", dut.wait_q, 32'h0);

        // RF id error
        inject_err = 2'b01;
        send(2'b01, 4'd6, 4'd0);
        chk("iderr_check", rf_check_o, 2'b00);
        exp_q0.push_back({4'd6, 1'b1});
        tick();
        inject_err = 2'b00;
        chk("iderr_rf_bit", rf_bits[6], 1'b0);
        tick();

        // Cross-release: each port gets its own response then the partner's
        send(2'b11, 4'd2, 4'd9);
        chk("xarm_check", rf_check_o, 2'b11);
        chk("xarm_bypass", rf_bypass_i, 1'b0);
        tick();
        send(2'b11, 4'd9, 4'd2);
        chk("xrel_check", rf_check_o, 2'b11);
        exp_q0.push_back({4'd9, 1'b0});
        exp_q0.push_back({4'd2, 1'b0});
        exp_q1.push_back({4'd2, 1'b0});
        exp_q1.push_back({4'd9, 1'b0});
        tick();
        tick();
        tick();
        chk("xrel_drained", rsp_valid_o, 2'b00);

        // Backpressure: three errors parked on port 0 leave one free entry
        rsp_ready_i = 2'b10;
        inject_err  = 2'b11;
        send(2'b01, 4'd1, 4'd0);
        send(2'b01, 4'd2, 4'd0);
        send(2'b01, 4'd3, 4'd0);
        exp_q0.push_back({4'd1, 1'b1});
        exp_q0.push_back({4'd2, 1'b1});
        exp_q0.push_back({4'd3, 1'b1});
        tick();
        send(2'b11, 4'hA, 4'hB);
        send(2'b11, 4'hD, 4'hC);
        exp_q0.push_back({4'hA, 1'b1});
        exp_q0.push_back({4'hD, 1'b1});
        exp_q1.push_back({4'hB, 1'b1});
        exp_q1.push_back({4'hC, 1'b1});
        chk("bp_req_ready_low", req_ready_o, 2'b00);
        tick();
        tick();
        chk("bp_no_issue", rf_check_o | {1'b0, rsp_valid_o[1]}, 2'b00);
        chk("bp_still_full", req_ready_o, 2'b00);
        rsp_ready_i = 2'b11;
        for (int i = 0; i < 20 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) tick();
        chk("bp_drain0", exp_q0.size(), 0);
        chk("bp_drain1", exp_q1.size(), 0);
        chk("bp_req_ready_back", req_ready_o, 2'b11);
        inject_err = 2'b00;

        // Mid-operation reset
        send(2'b01, 4'd4, 4'd0);
        tick();
        rsp_ready_i = 2'b00;
        inject_err  = 2'b01;
        send(2'b01, 4'd1, 4'd0);
        tick();
        inject_err = 2'b00;
        chk("mrst_pending_rsp", rsp_valid_o, 2'b01);
        send(2'b10, 4'd0, 4'd8);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mrst_rsp_valid", rsp_valid_o, 2'b00);
        chk("mrst_rsp_id", rsp_id_o, 8'h00);
        chk("mrst_rf_id", rf_id_o, 8'h10);
        chk("mrst_rf_check", rf_check_o, 2'b00);
        chk("mrst_req_ready", req_ready_o, 2'b11);
        chk("mrst_wait", dut.wait_q, 32'h0);
        rsp_ready_i = 2'b11;
        send(2'b10, 4'd0, 4'd4);
        chk("mrst_p1_check", rf_check_o, 2'b10);
        chk("mrst_p1_present", rf_present_i[1], 1'b0);
        tick();
        chk("mrst_p1_arms", dut.wait_q[1][4], 1'b1);
        tick();
        chk("mrst_no_rsp", rsp_valid_o, 2'b00);
        chk("end_q0_empty", exp_q0.size(), 0);
        chk("end_q1_empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
